puf_vote_ctrl: RTL and testbench
================================

Name: puf_vote_ctrl

Overview:
- Sequencer that drives one arbiter PUF instance (N-stage delay chain with latch decision element).
- Accepts a challenge over a valid/ready handshake and holds it stable on the PUF challenge bus.
- Fires K launch pulses with fixed settle and recover windows, synchronises and counts the K responses, and returns a majority-voted bit with stability info over a second valid/ready handshake.
- Sits between the PUF and the host/UART command logic on the Nexys A7.

Parameters:
- N, 64: challenge width; must equal the PUF stage count.
- K, 15: samples per challenge; odd, 1..255.
- SETTLE, 4: cycles launch is held high per sample; must be at least 3.
- RECOVER, 4: cycles launch is held low before each sample, with the challenge stable; at least 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  challenge request valid
- in_ready  out  1  controller can accept a challenge
- in_challenge  in  N  challenge to evaluate
- puf_challenge  out  N  registered challenge driven to the PUF
- puf_launch  out  1  registered launch to the PUF
- puf_response  in  1  raw PUF response; asynchronous to clk
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_resp  out  1  majority bit
- out_ones  out  CW  count of 1 samples, where CW = $clog2(K+1)
- out_stable  out  1  all K samples agreed
- busy  out  1  state is not IDLE

Behaviour:
- Reset is asynchronous and active-low (rst_n). On reset:
  - state = IDLE.
  - puf_launch = 0, puf_challenge = 0.
  - All counters = 0.
  - out_valid = 0, out_resp = 0, out_ones = 0, out_stable = 0.
  - Synchroniser flops = 0.
- puf_response passes through a 2-flop synchroniser (resp_s) before any use.
- in_ready = 1 only in IDLE (combinational from state). busy = (state != IDLE).
- IDLE:
  - On in_valid & in_ready: latch in_challenge into puf_challenge, clear the ones and sample counters, go to SETUP.
  - No other input has any effect in IDLE.
- SETUP:
  - puf_launch = 0; stay exactly RECOVER cycles (both paths return low; the decision latch holds its value), then go to LAUNCH.
- LAUNCH:
  - puf_launch = 1; stay exactly SETTLE cycles.
  - On the final LAUNCH cycle, resp_s is added to the ones counter and the sample counter increments.
  - If the sample count reaches K, go to DONE; otherwise go to SETUP.
- DONE:
  - out_valid = 1.
  - out_resp = (ones > K/2), using integer division.
  - out_ones = ones.
  - out_stable = (ones == 0) | (ones == K).
  - All outputs are registered and held stable while out_valid & !out_ready.
  - On out_valid & out_ready: out_valid deasserts and the state returns to IDLE.
  - Result fields keep their last values until the next DONE.
- puf_challenge changes only on an IDLE accept; it never changes while puf_launch = 1.
- puf_launch changes only on SETUP/LAUNCH transitions and is glitch-free because it is driven from a flop.
- Latency: out_valid rises exactly K*(RECOVER+SETTLE) cycles after the accept edge. With defaults this is 120 cycles.
- Throughput: at least 1 idle cycle between a result handshake and the next accept.
- Simultaneous events:
  - in_valid asserted while busy is ignored; the request is neither latched nor dropped, it simply waits.
  - out_ready asserted outside DONE has no effect.
- Reset mid-operation:
  - puf_launch drops to 0 asynchronously.
  - Any partial count is discarded and no out_valid is produced.
- Width rules: the ones counter is CW bits and never wraps (maximum K). The sample counter is CW bits. The wait counter is $clog2(max(SETTLE,RECOVER)+1) bits.
- Parameter checks: elaboration fails if K is even, K == 0, or SETTLE < 3.

Decomposition:
- Shared package puf_pkg holds:
  - the state enum (IDLE, SETUP, LAUNCH, DONE);
  - the CW width function;
  - the default N/K/SETTLE/RECOVER constants, also used by the top and the bench.
- One natural sub-module: puf_sync2, the 2-flop synchroniser with async active-low reset, reused by other PUF-side inputs.
- The top level instantiates puf_vote_ctrl and the arbiter PUF side by side.

Test Plan:
1. Reset: hold rst_n = 0 with random inputs -> puf_launch = 0, out_valid = 0, in_ready = 1, busy = 0. Assert rst_n = 0 mid-LAUNCH -> puf_launch = 0 in the same cycle, and no out_valid after release.
2. Stable-1 PUF model, challenge 64'hDEADBEEF00000001, defaults -> exactly 15 launch pulses, each 4 cycles high and 4 low. out_valid arrives 120 cycles after accept with out_resp = 1, out_ones = 15, out_stable = 1. puf_challenge is unchanged throughout.
3. Scripted noisy model, 5 of 15 samples = 1 -> out_resp = 0, out_ones = 5, out_stable = 0. Rerun with 8 of 15 -> out_resp = 1, out_ones = 8.
4. Backpressure: out_ready = 0 for 20 cycles in DONE, with a second in_valid held -> result fields constant, in_ready = 0, second challenge not latched. Release out_ready -> second challenge accepted after the one-cycle IDLE bubble.
5. Edge parameters K = 1, SETTLE = 3, RECOVER = 1: response toggling every cycle -> one sample per request, latency 4 cycles, out_stable = 1, out_ones equals the synchronised value at the final LAUNCH cycle.
6. Back-to-back: 100 random challenges with a parity-of-challenge PUF model and random out_ready -> every out_resp matches the model, with no lost or duplicated results.

Source files
------------

// File: rtl/puf_vote_ctrl_pkg.sv
// Shared types and defaults for the arbiter PUF majority-vote sequencer.
// Imported by the controller, its synchroniser and the bench.
package puf_pkg;

  localparam int N_DEF       = 64;
  localparam int K_DEF       = 15;
  localparam int SETTLE_DEF  = 4;
  localparam int RECOVER_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    LAUNCH,
    DONE
  } state_e;

  function automatic int cw_f(input int k);
    return $clog2(k + 1);
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/puf_vote_ctrl_if.sv
// Host-side request/result handshakes of the PUF vote controller.
// master = command logic, slave = controller.
interface puf_vote_ctrl_if #(
  parameter int N  = 64,
  parameter int CW = 4
);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_challenge;
  logic          out_valid;
  logic          out_ready;
  logic          out_resp;
  logic [CW-1:0] out_ones;
  logic          out_stable;

  modport master (
    output in_valid, in_challenge, out_ready,
    input  in_ready, out_valid, out_resp,
    input  out_ones, out_stable
  );

  modport slave (
    input  in_valid, in_challenge, out_ready,
    output in_ready, out_valid, out_resp,
    output out_ones, out_stable
  );

endinterface

// File: rtl/puf_vote_ctrl_sync2.sv
// Two-flop synchroniser for PUF-side signals that are asynchronous to clk.
// Async active-low reset clears both stages.
module puf_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/puf_vote_ctrl.sv
// Drives one arbiter PUF: K launch pulses per challenge, counts the
// synchronised responses and returns a majority bit with stability info.
module puf_vote_ctrl
  import puf_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int K       = K_DEF,
  parameter int SETTLE  = SETTLE_DEF,
  parameter int RECOVER = RECOVER_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  puf_vote_ctrl_if.slave host,
  output logic [N-1:0] puf_challenge,
  output logic         puf_launch,
  input  logic         puf_response,
  output logic         busy
);

  localparam int CW = cw_f(K);
  localparam int WW = cw_f(max_f(SETTLE, RECOVER));

  if ((K % 2 == 0) || (K < 1) || (K > 255) ||
      (SETTLE < 3) || (RECOVER < 1)) begin : g_bad_param
    $error("puf_vote_ctrl: illegal K/SETTLE/RECOVER");
  end

  state_e        state_q;
  logic [N-1:0]  chal_q;
  logic          launch_q;
  logic [WW-1:0] wait_q;
  logic [CW-1:0] smp_q;
  logic [CW-1:0] ones_q;
  logic [CW-1:0] ones_d;
  logic          valid_q;
  logic          resp_q;
  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          resp_s;

  puf_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (puf_response),
    .q     (resp_s)
  );

  assign ones_d = ones_q + CW'(resp_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      chal_q   <= '0;
      launch_q <= 1'b0;
      wait_q   <= '0;
      smp_q    <= '0;
      ones_q   <= '0;
      valid_q  <= 1'b0;
      resp_q   <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (host.in_valid) begin
            chal_q  <= host.in_challenge;
            ones_q  <= '0;
            smp_q   <= '0;
            wait_q  <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (wait_q == WW'(RECOVER - 1)) begin
            wait_q   <= '0;
            launch_q <= 1'b1;
            state_q  <= LAUNCH;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        LAUNCH: begin
          if (wait_q == WW'(SETTLE - 1)) begin
            wait_q   <= '0;
            launch_q <= 1'b0;
            ones_q   <= ones_d;
            smp_q    <= smp_q + 1'b1;
            // Result is built from ones_d so the last sample counts.
            if (smp_q == CW'(K - 1)) begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              resp_q   <= (ones_d > CW'(K / 2));
              cnt_q    <= ones_d;
              stable_q <= (ones_d == '0) ||
                          (ones_d == CW'(K));
            end else begin
              state_q <= SETUP;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        DONE: begin
          if (host.out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host.in_ready   = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign puf_challenge   = chal_q;
  assign puf_launch      = launch_q;
  assign host.out_valid  = valid_q;
  assign host.out_resp   = resp_q;
  assign host.out_ones   = cnt_q;
  assign host.out_stable = stable_q;

endmodule

// File: tb/tb_puf_vote_ctrl.sv
// Randomised bench for puf_vote_ctrl with a cycle-level behavioural model
// and an edge-parameter instance (K=1, SETTLE=3, RECOVER=1).
module tb_puf_vote_ctrl;
  import puf_pkg::*;

  localparam int N  = N_DEF;
  localparam int K  = K_DEF;
  localparam int S  = SETTLE_DEF;
  localparam int R  = RECOVER_DEF;
  localparam int P  = S + R;
  localparam int CW = cw_f(K);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  puf_vote_ctrl_if #(.N(N), .CW(CW)) hif ();
  puf_vote_ctrl_if #(.N(N), .CW(1))  eif ();

  logic [N-1:0] pchal, e_pchal;
  logic plaunch, e_launch, pbusy, e_busy;
  logic presp = 1'b0;
  logic e_resp = 1'b0;

  puf_vote_ctrl #(.N(N), .K(K), .SETTLE(S), .RECOVER(R)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host          (hif),
    .puf_challenge (pchal),
    .puf_launch    (plaunch),
    .puf_response  (presp),
    .busy          (pbusy)
  );

  puf_vote_ctrl #(.N(N), .K(1), .SETTLE(3), .RECOVER(1)) dut_e (
    .clk           (clk),
    .rst_n         (rst_n),
    .host          (eif),
    .puf_challenge (e_pchal),
    .puf_launch    (e_launch),
    .puf_response  (e_resp),
    .busy          (e_busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // PUF environment: 0 stable-1, 1 scripted, 2 parity, 3 random noise
  int mode = 3;
  logic [14:0] script = '0;
  int pidx = 0;
  logic lp = 1'b0;

  always @(negedge clk) begin
    if (mode == 3)
      presp = 1'($urandom_range(0, 1));
    else if (plaunch && !lp) begin
      case (mode)
        0:       presp = 1'b1;
        1:       presp = script[pidx % 15];
        default: presp = ^pchal;
      endcase
      pidx++;
    end
    lp = plaunch;
  end

  function automatic int exp_ones(input logic [N-1:0] c);
    int s;
    s = 0;
    case (mode)
      0: s = K;
      1: for (int i = 0; i < K; i++) s += int'(script[i]);
      2: s = (^c) ? K : 0;
      default: s = 0;
    endcase
    return s;
  endfunction

  // Model: time since accept decides launch and result timing
  bit m_busy, m_done, m_resp, m_stab;
  int m_t, m_exp, m_ones;
  logic [N-1:0] m_chal;
  int n_acc = 0;
  int n_res = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_t = 0; m_chal = '0;
      m_ones = 0; m_resp = 0; m_stab = 0; pidx = 0;
    end else if (!m_busy) begin
      if (hif.in_valid) begin
        m_busy = 1; m_t = 0;
        m_chal = hif.in_challenge;
        m_exp = exp_ones(hif.in_challenge);
        pidx = 0;
        n_acc++;
      end
    end else if (m_done) begin
      if (hif.out_ready) begin
        m_busy = 0; m_done = 0; n_res++;
      end
    end else begin
      m_t++;
      if (m_t == K * P) begin
        m_done = 1;
        m_ones = m_exp;
        m_resp = (m_exp > K / 2);
        m_stab = (m_exp == 0) || (m_exp == K);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", N'(hif.in_ready), N'(!m_busy));
      chk("busy", N'(pbusy), N'(m_busy));
      chk("launch", N'(plaunch),
          N'(m_busy && !m_done && ((m_t % P) >= R)));
      chk("out_valid", N'(hif.out_valid), N'(m_done));
      chk("puf_chal", pchal, m_chal);
      chk("out_resp", N'(hif.out_resp), N'(m_resp));
      chk("out_ones", N'(hif.out_ones), N'(m_ones));
      chk("out_stable", N'(hif.out_stable), N'(m_stab));
    end
  end

  // Edge instance: response toggles each cycle, history per posedge
  int ecyc = 0;
  bit hist [0:1023];
  bit tog_en = 0;
  always @(posedge clk) begin
    ecyc++;
    hist[ecyc % 1024] = e_resp;
  end
  always @(negedge clk) if (tog_en) e_resp = ~e_resp;

  task automatic run_one(input logic [N-1:0] c, output int lat,
                         output int pulses, output int badrun);
    int run;
    logic prev;
    bit seen;
    hif.in_challenge = c;
    hif.in_valid = 1'b1;
    hif.out_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = pbusy;
    end
    hif.in_valid = 1'b0;
    if (!seen) chk("accept_timeout", 0, 1);
    lat = 0; pulses = 0; badrun = 0; run = 1; prev = plaunch;
    while (!hif.out_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (plaunch != prev) begin
        if (prev ? (run != S) : (run != R)) badrun++;
        if (plaunch) pulses++;
        run = 1;
      end else run++;
      prev = plaunch;
    end
  endtask

  task automatic finish_one();
    hif.out_ready = 1'b1;
    @(negedge clk);
    hif.out_ready = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!hif.out_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, pulses, badrun, a, p, nv, sent, acc_seen, a0, r0;
    logic [N-1:0] c1, c2;
    hif.in_valid = 0; hif.in_challenge = '0; hif.out_ready = 0;
    eif.in_valid = 0; eif.in_challenge = '0; eif.out_ready = 0;

    // reset with random inputs
    repeat (5) begin
      @(negedge clk);
      hif.in_valid = 1'($urandom_range(0, 1));
      hif.in_challenge = {$urandom, $urandom};
      hif.out_ready = 1'($urandom_range(0, 1));
    end
    chk("rst_launch", N'(plaunch), 0);
    chk("rst_valid", N'(hif.out_valid), 0);
    chk("rst_in_ready", N'(hif.in_ready), 1);
    chk("rst_busy", N'(pbusy), 0);
    chk("rst_chal", pchal, 0);
    hif.in_valid = 0; hif.out_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // stable-1 PUF
    mode = 0;
    @(negedge clk);
    run_one(64'hDEADBEEF00000001, lat, pulses, badrun);
    chk("s1_latency", N'(lat), 120);
    chk("s1_pulses", N'(pulses), 15);
    chk("s1_badrun", N'(badrun), 0);
    chk("s1_resp", N'(hif.out_resp), 1);
    chk("s1_ones", N'(hif.out_ones), 15);
    chk("s1_stable", N'(hif.out_stable), 1);
    chk("s1_chal", pchal, 64'hDEADBEEF00000001);
    finish_one();

    // scripted noise: 5 of 15, then 8 of 15
    mode = 1;
    script = 15'b101000001010001;
    @(negedge clk);
    run_one(64'h1234, lat, pulses, badrun);
    chk("n5_ones", N'(hif.out_ones), 5);
    chk("n5_resp", N'(hif.out_resp), 0);
    chk("n5_stable", N'(hif.out_stable), 0);
    finish_one();
    script = 15'b110110100101100;
    @(negedge clk);
    run_one(64'h5678, lat, pulses, badrun);
    chk("n8_ones", N'(hif.out_ones), 8);
    chk("n8_resp", N'(hif.out_resp), 1);
    chk("n8_stable", N'(hif.out_stable), 0);
    finish_one();

    // backpressure with a queued second request
    mode = 2;
    c1 = {$urandom, $urandom} | 64'h1;
    c1[63] = ~^c1[62:0];
    c2 = {$urandom, $urandom};
    @(negedge clk);
    run_one(c1, lat, pulses, badrun);
    hif.in_challenge = c2;
    hif.in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("bp_in_ready", N'(hif.in_ready), 0);
      chk("bp_chal", pchal, c1);
      chk("bp_ones", N'(hif.out_ones), 15);
    end
    hif.out_ready = 1'b1;
    @(negedge clk);
    hif.out_ready = 1'b0;
    chk("bubble_busy", N'(pbusy), 0);
    chk("bubble_ready", N'(hif.in_ready), 1);
    @(negedge clk);
    chk("bp2_busy", N'(pbusy), 1);
    chk("bp2_chal", pchal, c2);
    hif.in_valid = 1'b0;
    wait_done();
    chk("bp2_ones", N'(hif.out_ones), (^c2) ? 15 : 0);
    finish_one();

    // edge parameters with a toggling response
    tog_en = 1;
    eif.out_ready = 1'b1;
    for (int rep = 0; rep < 3; rep++) begin
      repeat (rep + 1) @(negedge clk);
      eif.in_valid = 1'b1;
      @(posedge clk);
      #1 a = ecyc;
      eif.in_valid = 1'b0;
      nv = 0;
      while (!eif.out_valid && nv < 20) begin
        @(negedge clk);
        nv++;
      end
      p = ecyc;
      chk("e_latency", N'(p - a), 4);
      chk("e_ones", N'(eif.out_ones), N'(hist[(p - 2) % 1024]));
      chk("e_resp", N'(eif.out_resp), N'(hist[(p - 2) % 1024]));
      chk("e_stable", N'(eif.out_stable), 1);
      chk("e_launch", N'(e_launch), 0);
      @(negedge clk);
      chk("e_idle", N'(e_busy), 0);
    end
    tog_en = 0;
    eif.out_ready = 1'b0;

    // reset in the middle of LAUNCH
    mode = 3;
    @(negedge clk);
    hif.in_challenge = 64'hA5A5;
    hif.in_valid = 1'b1;
    nv = 0;
    while (!plaunch && nv < 50) begin
      @(negedge clk);
      nv++;
    end
    hif.in_valid = 1'b0;
    chk("mid_launch_seen", N'(plaunch), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_launch", N'(plaunch), 0);
    chk("mid_rst_busy", N'(pbusy), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    nv = 0;
    repeat (200) begin
      @(negedge clk);
      if (hif.out_valid) nv++;
    end
    chk("mid_rst_no_valid", N'(nv), 0);

    // random scripted noise, one request at a time
    mode = 1;
    for (int i = 0; i < 6; i++) begin
      script = 15'($urandom);
      @(negedge clk);
      run_one({$urandom, $urandom}, lat, pulses, badrun);
      chk("rn_ones", N'(hif.out_ones), N'($countones(script)));
      chk("rn_latency", N'(lat), K * P);
      finish_one();
    end

    // back-to-back random challenges, random out_ready
    mode = 2;
    sent = 0;
    a0 = n_acc;
    r0 = n_res;
    acc_seen = n_acc;
    for (int cyc = 0; cyc < 40000 && (n_res - r0) < 100; cyc++) begin
      @(negedge clk);
      hif.out_ready = 1'($urandom_range(0, 1));
      if (hif.in_valid && n_acc != acc_seen) begin
        hif.in_valid = 1'b0;
        acc_seen = n_acc;
      end
      if (!hif.in_valid && sent < 100 && $urandom_range(0, 3) == 0) begin
        hif.in_challenge = {$urandom, $urandom};
        hif.in_valid = 1'b1;
        sent++;
      end
    end
    hif.out_ready = 1'b0;
    hif.in_valid = 1'b0;
    chk("b2b_accepts", N'(n_acc - a0), 100);
    chk("b2b_results", N'(n_res - r0), 100);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
